i2c_dac_writer: RTL and testbench
=================================

I2C_DAC_WRITER -- requirements
Module: i2c_dac_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, clk_in cycles per quarter bit-phase, legal range 2..1023.
REQ-002 SHALL have parameter ADDR_BASE, default 7'h0C, 7-bit I2C base address; the low CHIP_BITS bits are replaced by cmd_chip.
REQ-003 SHALL have parameter CHIP_BITS, default 1, chip-select width, legal range 1..3.
REQ-004 SHALL have parameter CHAN_BITS, default 4, DAC channel width, legal range 1..8.
REQ-005 SHALL have parameter DATA_BITS, default 12, DAC code width, legal range 1..16.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_in, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1 bit: a write command is offered.
REQ-009 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-010 SHALL have port cmd_chip, input, CHIP_BITS bits: target chip select.
REQ-011 SHALL have port cmd_chan, input, CHAN_BITS bits: DAC channel.
REQ-012 SHALL have port cmd_data, input, DATA_BITS bits: DAC code.
REQ-013 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low, 0 releases it.
REQ-014 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-015 SHALL have port sda_in, input, 1 bit: sampled SDA line, already synchronised externally.
REQ-016 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-018 SHALL have port nack, output, 1 bit: valid with done; 1 means the frame was aborted on a NACK.

Function
REQ-019 SHALL accept a command on a clk_in edge where cmd_valid && cmd_ready, and latch cmd_chip, cmd_chan and cmd_data; later input changes SHALL have no effect on the frame.
REQ-020 SHALL drive cmd_ready = 1 only in IDLE, and cmd_ready = 0 on the cycle after acceptance.
REQ-021 SHALL ignore cmd_valid while busy, so no command is queued.
REQ-022 SHALL send four bytes MSB first, each followed by an ACK slot:
  - B0 = {ADDR_BASE[6:CHIP_BITS], chip, 0}
  - B1 = chan, zero-extended to 8 bits
  - B2 = data left-justified to 16 bits, bits [15:8]
  - B3 = data left-justified to 16 bits, bits [7:0]
REQ-023 SHALL sequence the frame with the FSM states IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> IDLE, each phase lasting CLK_DIV cycles.
REQ-024 SHALL make START 2 phases: (SCL released, SDA low), then (SCL low, SDA low).
REQ-025 SHALL make each BIT or ACK slot 4 phases, with SCL low, low, released, released.
REQ-026 SHALL change SDA only at the start of phase 0 of a slot.
REQ-027 SHALL release SDA during ACK slots.
REQ-028 SHALL sample sda_in on the last cycle of phase 2 of each ACK slot.
REQ-029 SHALL make STOP 3 phases: (SCL low, SDA low), (SCL released, SDA low), (SCL released, SDA released).
REQ-030 SHALL, when the sampled ACK is 1 (NACK), go to STOP directly after that ACK slot, skip the remaining bytes, and assert nack with done.
REQ-031 SHALL, on a fully ACKed frame, assert done exactly 149*CLK_DIV cycles after the acceptance edge, with nack = 0.
REQ-032 SHALL, on a NACK at byte k (0..3), assert done (2 + 36*(k+1) + 3)*CLK_DIV cycles after acceptance.
REQ-033 SHALL hold busy = 1 from the cycle after acceptance through the last STOP cycle; in the cycle where done = 1, busy = 0 and cmd_ready = 1.
REQ-034 SHALL allow a back-to-back command to be accepted in the same cycle as done; the bus idle gap is then 0 extra phases.
REQ-035 SHALL never issue an SCL or SDA change shorter than CLK_DIV cycles, for any legal parameter set.
REQ-036 SHALL NOT support clock stretching; SCL is never read back.

Reset
REQ-037 SHALL, while reset_in = 0, force immediately (asynchronously) scl_oe = 0, sda_oe = 0, busy = 0, done = 0, nack = 0, FSM = IDLE, and clear all counters.
REQ-038 SHALL, when reset is asserted mid-frame, abandon the frame with no STOP and no done pulse.
REQ-039 SHALL raise cmd_ready on the first clk_in edge after reset_in deasserts.

Structure
REQ-040 SHALL place the FSM state enum, the phase counts (START 2, SLOT 4, STOP 3), BYTES_PER_FRAME = 4 and FRAME_PHASES = 149 in shared package i2c_dac_pkg.
REQ-041 SHALL use one sub-module, i2c_phase_timer, which emits a one-cycle tick every CLK_DIV cycles and is restarted on acceptance.
REQ-042 SHALL keep all bus outputs registered, with no combinational path from sda_in or cmd_* to scl_oe or sda_oe.

Verification
REQ-043 SHALL cover the full write: CLK_DIV=4, chip=1, chan=5, data=12'hABC, all ACKs low -> bytes 0x1A, 0x05, 0xAB, 0xC0 decoded by the bus monitor; done at 596 cycles; nack = 0.
REQ-044 SHALL cover an address NACK: sda_in held high in the first ACK slot -> STOP follows immediately; done with nack = 1 at 164 cycles; no further SCL pulses.
REQ-045 SHALL cover back-to-back commands: cmd_valid held high with 2 commands -> the second is accepted on the done cycle; two complete frames; exactly 2 done pulses.
REQ-046 SHALL cover reset mid-frame: reset_in low at cycle 300 -> scl_oe = 0 and sda_oe = 0 within the same cycle; no done; cmd_ready = 1 on the first edge after release.
REQ-047 SHALL cover parameter corners: CLK_DIV=2, DATA_BITS=16, CHAN_BITS=8, data=16'hFFFF, chan=8'hFF -> bytes {B0, 0xFF, 0xFF, 0xFF}; done at 298 cycles; no bus edge spacing below 2 cycles.

Source files
------------

// File: rtl/i2c_dac_pkg.sv
// Shared definitions for the I2C DAC writer: FSM encoding and frame geometry.
// Phase counts are in quarter-bit phases of CLK_DIV clock cycles each.
package i2c_dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int START_PHASES    = 2;
  localparam int SLOT_PHASES     = 4;
  localparam int STOP_PHASES     = 3;
  localparam int BITS_PER_BYTE   = 8;
  localparam int BYTES_PER_FRAME = 4;
  localparam int FRAME_PHASES    = START_PHASES
                                 + BYTES_PER_FRAME * (BITS_PER_BYTE + 1) * SLOT_PHASES
                                 + STOP_PHASES;

  // Frame is sent MSB first: address byte (R/W = 0), channel, data high, data low.
  function automatic logic [31:0] pack_frame(input logic [6:0]  addr,
                                             input logic [7:0]  chan,
                                             input logic [15:0] data);
    return {addr, 1'b0, chan, data};
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Free-running divider producing a one-cycle tick every CLK_DIV cycles.
// A restart pulse realigns the count so the next tick lands CLK_DIV cycles later.
module i2c_phase_timer #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/i2c_dac_writer.sv
// Write-only I2C master sending a fixed 4-byte DAC update frame per command.
// All bus outputs are registered and change only on phase-timer ticks.
module i2c_dac_writer
  import i2c_dac_pkg::*;
#(
  parameter int         CLK_DIV   = 25,
  parameter logic [6:0] ADDR_BASE = 7'h0C,
  parameter int         CHIP_BITS = 1,
  parameter int         CHAN_BITS = 4,
  parameter int         DATA_BITS = 12
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CHIP_BITS-1:0] cmd_chip,
  input  logic [CHAN_BITS-1:0] cmd_chan,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 scl_oe,
  output logic                 sda_oe,
  input  logic                 sda_in,
  output logic                 busy,
  output logic                 done,
  output logic                 nack
);

  // Command handshake: a command transfers on a clk_in edge where
  // cmd_valid && cmd_ready; cmd_ready is high only while idle, so nothing queues.

  localparam logic [1:0] START_LAST = 2'(START_PHASES - 1);
  localparam logic [1:0] SLOT_LAST  = 2'(SLOT_PHASES - 1);
  localparam logic [1:0] STOP_LAST  = 2'(STOP_PHASES - 1);
  localparam logic [1:0] BYTE_LAST  = 2'(BYTES_PER_FRAME - 1);
  localparam logic [2:0] BIT_LAST   = 3'(BITS_PER_BYTE - 1);

  state_t      state;
  logic [1:0]  phase;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic        ack_bit;
  logic        tick;
  logic        accept;
  logic [6:0]  addr;
  logic [31:0] frame;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    addr                 = ADDR_BASE;
    addr[CHIP_BITS-1:0]  = cmd_chip;
    frame = pack_frame(addr, 8'(cmd_chan), 16'(cmd_data) << (16 - DATA_BITS));
  end

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .restart  (accept),
    .tick     (tick)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      phase     <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      ack_bit   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      nack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            phase     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= frame;
            ack_bit   <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        START: if (tick) begin
          scl_oe <= 1'b1;
          if (phase == START_LAST) begin
            state  <= BIT;
            phase  <= '0;
            sda_oe <= ~shreg[31];
          end else begin
            phase <= phase + 2'd1;
          end
        end
        BIT: if (tick) begin
          if (phase == SLOT_LAST) begin
            phase  <= '0;
            scl_oe <= 1'b1;
            shreg  <= {shreg[30:0], 1'b0};
            if (bit_idx == BIT_LAST) begin
              state  <= ACK;
              sda_oe <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sda_oe  <= ~shreg[30];
            end
          end else begin
            phase  <= phase + 2'd1;
            scl_oe <= (phase == 2'd0);
          end
        end
        ACK: if (tick) begin
          // Slave response is taken at the end of the SCL-high window's first half.
          if (phase == 2'd2) ack_bit <= sda_in;
          if (phase == SLOT_LAST) begin
            phase  <= '0;
            scl_oe <= 1'b1;
            if (ack_bit || byte_idx == BYTE_LAST) begin
              state  <= STOP;
              sda_oe <= 1'b1;
            end else begin
              state    <= BIT;
              byte_idx <= byte_idx + 2'd1;
              bit_idx  <= '0;
              sda_oe   <= ~shreg[31];
            end
          end else begin
            phase  <= phase + 2'd1;
            scl_oe <= (phase == 2'd0);
          end
        end
        STOP: if (tick) begin
          if (phase == STOP_LAST) begin
            state     <= IDLE;
            phase     <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            nack      <= ack_bit;
            cmd_ready <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
          end else begin
            phase  <= phase + 2'd1;
            scl_oe <= 1'b0;
            sda_oe <= (phase == 2'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_dac_writer.sv
// Directed bench for i2c_dac_writer: two instances (CLK_DIV=4 defaults, and a
// CLK_DIV=2 wide-field corner) observed through a shared bus monitor.
module tb_i2c_dac_writer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: CLK_DIV=4, default widths ----------------
  logic        cmd_valid_a = 1'b0, cmd_ready_a;
  logic [0:0]  cmd_chip_a = '0;
  logic [3:0]  cmd_chan_a = '0;
  logic [11:0] cmd_data_a = '0;
  logic        scl_oe_a, sda_oe_a, busy_a, done_a, nack_a;
  logic        sda_in_a = 1'b0;

  i2c_dac_writer #(.CLK_DIV(4)) dut_a (
    .clk_in(clk), .reset_in(rst_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_chip(cmd_chip_a), .cmd_chan(cmd_chan_a), .cmd_data(cmd_data_a),
    .scl_oe(scl_oe_a), .sda_oe(sda_oe_a), .sda_in(sda_in_a),
    .busy(busy_a), .done(done_a), .nack(nack_a)
  );

  // ---------------- DUT B: CLK_DIV=2, 8-bit chan, 16-bit data ----------------
  logic        cmd_valid_b = 1'b0, cmd_ready_b;
  logic [0:0]  cmd_chip_b = '0;
  logic [7:0]  cmd_chan_b = '0;
  logic [15:0] cmd_data_b = '0;
  logic        scl_oe_b, sda_oe_b, busy_b, done_b, nack_b;
  logic        sda_in_b = 1'b0;

  i2c_dac_writer #(.CLK_DIV(2), .CHAN_BITS(8), .DATA_BITS(16)) dut_b (
    .clk_in(clk), .reset_in(rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_chip(cmd_chip_b), .cmd_chan(cmd_chan_b), .cmd_data(cmd_data_b),
    .scl_oe(scl_oe_b), .sda_oe(sda_oe_b), .sda_in(sda_in_b),
    .busy(busy_b), .done(done_b), .nack(nack_b)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // ---------------- bus monitor (line levels, sampled on negedge) ----------------
  bit   mon_sel = 1'b0;
  logic scl_m, sda_m;
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic [8:0] mon_sh = '0;
  int bit_cnt = 0, scl_rises = 0, stops = 0, starts = 0;
  int scl_hold = 1000, sda_hold = 1000, scl_min = 1000, sda_min = 1000;
  int done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    scl_m = mon_sel ? ~scl_oe_b : ~scl_oe_a;
    sda_m = mon_sel ? ~sda_oe_b : ~sda_oe_a;
    if (scl_m && !scl_p) begin
      scl_rises++;
      mon_sh = {mon_sh[7:0], sda_m};
      bit_cnt++;
      if (bit_cnt == 9) begin
        got_q.push_back(mon_sh[8:1]);
        bit_cnt = 0;
      end
    end
    if (scl_m && scl_p && sda_p && !sda_m) begin starts++; bit_cnt = 0; end
    if (scl_m && scl_p && !sda_p && sda_m) begin stops++;  bit_cnt = 0; end
    if (scl_m != scl_p) begin
      if (scl_hold < scl_min) scl_min = scl_hold;
      scl_hold = 1;
    end else scl_hold++;
    if (sda_m != sda_p) begin
      if (sda_hold < sda_min) sda_min = sda_hold;
      sda_hold = 1;
    end else sda_hold++;
    scl_p = scl_m;
    sda_p = sda_m;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers a command and returns #1 after the edge that accepts it.
  task automatic send_a(input logic [0:0] chip, input logic [3:0] chan, input logic [11:0] data);
    int w;
    cmd_chip_a = chip; cmd_chan_a = chan; cmd_data_a = data; cmd_valid_a = 1'b1;
    w = 0;
    while (!cmd_ready_a && w < 1000) begin step(1); w++; end
    step(1);
  endtask

  task automatic send_b(input logic [0:0] chip, input logic [7:0] chan, input logic [15:0] data);
    int w;
    cmd_chip_b = chip; cmd_chan_b = chan; cmd_data_b = data; cmd_valid_b = 1'b1;
    w = 0;
    while (!cmd_ready_b && w < 1000) begin step(1); w++; end
    step(1);
  endtask

  // Counts edges after acceptance until done; an expired budget returns the limit.
  task automatic wait_done(input bit which, input int limit, output int n);
    n = 0;
    while (!(which ? done_b : done_a) && n < limit) begin step(1); n++; end
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check({tag, "_byte"}, g, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, d0, r0, s0;

    // Reset state
    #1;
    check("rst_scl_oe", scl_oe_a, 0);
    check("rst_sda_oe", sda_oe_a, 0);
    check("rst_busy",   busy_a,   0);
    check("rst_done",   done_a,   0);
    check("rst_nack",   nack_a,   0);
    check("rst_ready",  cmd_ready_a, 0);
    step(3);
    rst_n = 1'b1;
    step(1);
    check("ready_after_release", cmd_ready_a, 1);

    // Full write: chip 1, chan 5, data ABC -> 1A 05 AB C0, done at 596
    got_q.delete(); exp_q.delete();
    scl_min = 1000; sda_min = 1000; scl_hold = 1000; sda_hold = 1000;
    r0 = scl_rises; s0 = stops;
    send_a(1'b1, 4'd5, 12'hABC);
    cmd_valid_a = 1'b0;
    cmd_data_a = 12'h000; cmd_chan_a = 4'd0;
    check("full_busy_after_accept",  busy_a, 1);
    check("full_ready_after_accept", cmd_ready_a, 0);
    wait_done(1'b0, 2000, n);
    check("full_done_cycle", n, 596);
    check("full_nack", nack_a, 0);
    check("full_busy_at_done", busy_a, 0);
    check("full_ready_at_done", cmd_ready_a, 1);
    step(1);
    check("full_done_pulse_width", done_a, 0);
    exp_q.push_back(8'h1A); exp_q.push_back(8'h05);
    exp_q.push_back(8'hAB); exp_q.push_back(8'hC0);
    step(10);
    check_bytes("full");
    check("full_scl_rises", scl_rises - r0, 37);
    check("full_stops", stops - s0, 1);
    check("full_scl_min_ge4", scl_min >= 4, 1);
    check("full_sda_min_ge4", sda_min >= 4, 1);

    // Address NACK: done with nack at 164, no further SCL pulses
    got_q.delete(); exp_q.delete();
    r0 = scl_rises; s0 = stops;
    sda_in_a = 1'b1;
    send_a(1'b1, 4'd2, 12'h123);
    cmd_valid_a = 1'b0;
    wait_done(1'b0, 2000, n);
    check("nack_done_cycle", n, 164);
    check("nack_flag", nack_a, 1);
    check("nack_busy_at_done", busy_a, 0);
    step(40);
    check("nack_scl_rises", scl_rises - r0, 10);
    check("nack_stops", stops - s0, 1);
    exp_q.push_back(8'h1A);
    check_bytes("nack");
    sda_in_a = 1'b0;

    // Back-to-back: valid held, second command taken on the done cycle
    got_q.delete(); exp_q.delete();
    d0 = done_cnt_a;
    send_a(1'b0, 4'd3, 12'h123);
    cmd_chip_a = 1'b1; cmd_chan_a = 4'hF; cmd_data_a = 12'hFFF;
    wait_done(1'b0, 2000, n);
    check("b2b_first_done_cycle", n, 596);
    check("b2b_ready_at_done", cmd_ready_a, 1);
    step(1);
    cmd_valid_a = 1'b0;
    check("b2b_second_accepted", busy_a, 1);
    wait_done(1'b0, 2000, n);
    check("b2b_second_done_cycle", n, 596);
    step(20);
    check("b2b_done_pulses", done_cnt_a - d0, 2);
    exp_q.push_back(8'h18); exp_q.push_back(8'h03);
    exp_q.push_back(8'h12); exp_q.push_back(8'h30);
    exp_q.push_back(8'h1A); exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hF0);
    check_bytes("b2b");

    // Reset mid-frame at cycle 300 (byte 2 MSB slot, phase 1)
    d0 = done_cnt_a;
    send_a(1'b1, 4'd5, 12'h5BC);
    cmd_valid_a = 1'b0;
    step(300);
    check("mid_scl_before_reset", scl_oe_a, 1);
    check("mid_sda_before_reset", sda_oe_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_scl_in_reset",  scl_oe_a, 0);
    check("mid_sda_in_reset",  sda_oe_a, 0);
    check("mid_busy_in_reset", busy_a, 0);
    step(3);
    check("mid_ready_in_reset", cmd_ready_a, 0);
    rst_n = 1'b1;
    step(1);
    check("mid_ready_first_edge", cmd_ready_a, 1);
    step(50);
    check("mid_busy_after", busy_a, 0);
    check("mid_no_done", done_cnt_a - d0, 0);

    // Parameter corner on DUT B: chip 0, chan FF, data FFFF -> 18 FF FF FF, done 298
    mon_sel = 1'b1;
    step(2);
    got_q.delete(); exp_q.delete();
    scl_min = 1000; sda_min = 1000; scl_hold = 1000; sda_hold = 1000;
    d0 = done_cnt_b;
    send_b(1'b0, 8'hFF, 16'hFFFF);
    cmd_valid_b = 1'b0;
    wait_done(1'b1, 2000, n);
    check("corner_done_cycle", n, 298);
    check("corner_nack", nack_b, 0);
    step(10);
    exp_q.push_back(8'h18); exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    check_bytes("corner");
    check("corner_done_pulses", done_cnt_b - d0, 1);
    check("corner_scl_min_ge2", scl_min >= 2, 1);
    check("corner_sda_min_ge2", sda_min >= 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
